// File: rtl/c_fetch_align.sv
// c_fetch_align
//   Fetch-stage aligner. It fetches word-aligned 32-bit words from instruction
//   memory and keeps them in a small circular halfword queue. Each handshake
//   emits one raw instruction: a 16-bit RVC instruction (zero-extended) or a
//   full 32-bit instruction, which may straddle two fetched words. Every
//   instruction carries its exact PC and a length flag.
//
// Ports
//   clk, rst_n        clock and synchronous active-low reset
//   flush_i           redirect request; highest priority
//   redirect_pc_i     redirect target (bit 0 ignored, bit 1 selects upper half)
//   fetch_addr_o      word-aligned imem address
//   imem_word_i       imem data for fetch_addr_o, same cycle
//   imem_valid_i      imem_word_i valid
//   imem_ready_o      aligner accepts a word this cycle
//   inst_o            raw instruction ({16'h0, hw} when compressed)
//   inst_pc_o         PC of inst_o
//   inst_is_comp_o    inst_o is a 16-bit instruction
//   inst_illegal_o    head halfword is all zeros
//   inst_valid_o      inst_o valid
//   inst_ready_i      consumer takes inst_o
module c_fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned HW_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] fetch_addr_o,
  input  logic [31:0] imem_word_i,
  input  logic        imem_valid_i,
  output logic        imem_ready_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_is_comp_o,
  output logic        inst_illegal_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PTR_W = $clog2(HW_DEPTH);
  localparam int unsigned CNT_W = $clog2(HW_DEPTH + 1);
  // A full word (two halfwords) must fit after this cycle's pop.
  localparam logic [CNT_W-1:0] PUSH_LIMIT = CNT_W'(HW_DEPTH - 2);

  logic [15:0]      hw_q [HW_DEPTH];
  logic [15:0]      hw_d [HW_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             skip_lo_q, skip_lo_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      pc_q, pc_d;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [15:0]      head_hw;
  logic [15:0]      next_hw;
  logic             is_comp;
  logic             inst_valid;
  logic             pop;
  logic [1:0]       pop_cnt;
  logic [1:0]       push_cnt;
  logic [CNT_W-1:0] count_after_pop;
  logic             imem_ready;
  logic             accept;
  logic             unused_redirect_b0;

  // Modular pointer advance; HW_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0]       n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(HW_DEPTH)) s = s - (PTR_W+1)'(HW_DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign unused_redirect_b0 = redirect_pc_i[0];

  // Output decode from registered queue state only.
  always_comb begin
    head_p1         = ptr_add(head_q, 2'd1);
    tail_p1         = ptr_add(tail_q, 2'd1);
    head_hw         = hw_q[head_q];
    next_hw         = hw_q[head_p1];
    is_comp         = (head_hw[1:0] != 2'b11);
    inst_valid      = is_comp ? (count_q != '0) : (count_q >= CNT_W'(2));
    pop             = inst_valid && inst_ready_i;
    pop_cnt         = !pop ? 2'd0 : (is_comp ? 2'd1 : 2'd2);
    count_after_pop = count_q - CNT_W'(pop_cnt);
    imem_ready      = rst_n && !flush_i && (count_after_pop <= PUSH_LIMIT);
    accept          = imem_valid_i && imem_ready;
    push_cnt        = !accept ? 2'd0 : (skip_lo_q ? 2'd1 : 2'd2);
  end

  always_comb begin
    hw_d         = hw_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    skip_lo_d    = skip_lo_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;

    if (flush_i) begin
      // Redirect drops the queue and anything arriving this cycle.
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      skip_lo_d    = redirect_pc_i[1];
      fetch_addr_d = {redirect_pc_i[31:2], 2'b00};
      pc_d         = {redirect_pc_i[31:1], 1'b0};
    end else begin
      if (pop) begin
        head_d = ptr_add(head_q, pop_cnt);
        pc_d   = pc_q + {29'd0, pop_cnt, 1'b0};
      end
      if (accept) begin
        if (skip_lo_q) begin
          // Redirect landed on the upper half: the lower halfword is not ours.
          hw_d[tail_q] = imem_word_i[31:16];
          skip_lo_d    = 1'b0;
        end else begin
          hw_d[tail_q]  = imem_word_i[15:0];
          hw_d[tail_p1] = imem_word_i[31:16];
        end
        tail_d       = ptr_add(tail_q, push_cnt);
        fetch_addr_d = fetch_addr_q + 32'd4;
      end
      count_d = count_after_pop + CNT_W'(push_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(HW_DEPTH); i++) hw_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      skip_lo_q    <= 1'b0;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC;
    end else begin
      hw_q         <= hw_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      skip_lo_q    <= skip_lo_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
    end
  end

  assign fetch_addr_o   = fetch_addr_q;
  assign imem_ready_o   = imem_ready;
  assign inst_o         = is_comp ? {16'h0000, head_hw} : {next_hw, head_hw};
  assign inst_pc_o      = pc_q;
  assign inst_is_comp_o = is_comp;
  assign inst_illegal_o = inst_valid && (head_hw == 16'h0000);
  assign inst_valid_o   = inst_valid;

endmodule
